// File: rtl/dm_lat.sv
// Data memory for the MEM stage: request/response handshake, programmable commit latency,
// byte/half/word access with sign/zero extension, alignment and range checking.
module dm_lat #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned TRACE   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [31:0] req_pc_i,
  output logic        busy_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam bit          NoWait  = (LATENCY == 0);
  localparam logic [3:0]  CntInit = NoWait ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [Depth];

  logic        in_idle, accept, req_err, commit;
  logic        op_we, op_signed;
  logic [1:0]  op_size, lane;
  logic [31:0] op_addr, op_wdata, op_pc;
  logic [ADDR_W-1:0] op_idx;
  logic [31:0] old_word, wr_word, ld_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign in_idle = (state_q == StIdle);
  assign accept  = req_valid_i && in_idle;
  assign req_err = (req_size_i == 2'd3) ||
                   (req_size_i == 2'd1 && req_addr_i[0]) ||
                   (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00) ||
                   ((req_addr_i >> (ADDR_W + 2)) != 32'd0);

  // With no wait cycles the access commits at the accept edge, straight from the inputs.
  assign op_we     = in_idle ? req_we_i     : we_q;
  assign op_size   = in_idle ? req_size_i   : size_q;
  assign op_signed = in_idle ? req_signed_i : signed_q;
  assign op_addr   = in_idle ? req_addr_i   : addr_q;
  assign op_wdata  = in_idle ? req_wdata_i  : wdata_q;
  assign op_pc     = in_idle ? req_pc_i     : pc_q;

  assign commit = (accept && !req_err && NoWait) || (state_q == StWait && cnt_q == 4'd0);

  assign op_idx   = op_addr[ADDR_W+1:2];
  assign lane     = op_addr[1:0];
  assign old_word = mem_q[op_idx];
  assign byte_sel = old_word[{lane, 3'b000} +: 8];
  assign half_sel = old_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    wr_word = old_word;
    ld_word = old_word;
    case (op_size)
      2'd0: begin
        wr_word[{lane, 3'b000} +: 8] = op_wdata[7:0];
        ld_word = {{24{op_signed & byte_sel[7]}}, byte_sel};
      end
      2'd1: begin
        wr_word[{lane[1], 4'b0000} +: 16] = op_wdata[15:0];
        ld_word = {{16{op_signed & half_sel[15]}}, half_sel};
      end
      default: begin
        wr_word = op_wdata;
        ld_word = old_word;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err || NoWait) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (accept && req_err) begin
      rdata_d = 32'd0;
      err_d   = 1'b1;
    end else if (commit) begin
      rdata_d = op_we ? 32'd0 : ld_word;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      pc_q     <= 32'd0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q     <= req_we_i;
        size_q   <= req_size_i;
        signed_q <= req_signed_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
        pc_q     <= req_pc_i;
      end
      if (commit && op_we) begin
        mem_q[op_idx] <= wr_word;
      end
    end
  end

  always @(posedge clk) begin
    if (TRACE != 0 && !reset && commit && op_we) begin
      $display("%d@%h: *%h <= %h", $time, op_pc, {op_addr[31:2], 2'b00}, wr_word);
    end
  end

  assign busy_o       = !in_idle;
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dm_lat.sv
// Bench for dm_lat: three instances (LATENCY 1, 3, 0) checked against a byte-addressed
// reference memory, a directed vector table and hand-written handshake sequences.
module tb_dm_lat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst, rv, busy, rvld, rerr;
  logic [31:0] rdata [3];
  logic        we, sgn;
  logic [1:0]  size;
  logic [31:0] addr, wdata, pc;

  int checks = 0;
  int errors = 0;
  int lat [3] = '{1, 3, 0};
  logic [7:0] ref_mem [3][16384];

  dm_lat #(.ADDR_W(12), .LATENCY(1), .TRACE(1)) u_l1 (
    .clk(clk), .reset(rst[0]), .req_valid_i(rv[0]), .req_we_i(we), .req_size_i(size),
    .req_signed_i(sgn), .req_addr_i(addr), .req_wdata_i(wdata), .req_pc_i(pc),
    .busy_o(busy[0]), .resp_valid_o(rvld[0]), .resp_rdata_o(rdata[0]), .resp_err_o(rerr[0])
  );
  dm_lat #(.ADDR_W(12), .LATENCY(3), .TRACE(0)) u_l3 (
    .clk(clk), .reset(rst[1]), .req_valid_i(rv[1]), .req_we_i(we), .req_size_i(size),
    .req_signed_i(sgn), .req_addr_i(addr), .req_wdata_i(wdata), .req_pc_i(pc),
    .busy_o(busy[1]), .resp_valid_o(rvld[1]), .resp_rdata_o(rdata[1]), .resp_err_o(rerr[1])
  );
  dm_lat #(.ADDR_W(12), .LATENCY(0), .TRACE(0)) u_l0 (
    .clk(clk), .reset(rst[2]), .req_valid_i(rv[2]), .req_we_i(we), .req_size_i(size),
    .req_signed_i(sgn), .req_addr_i(addr), .req_wdata_i(wdata), .req_pc_i(pc),
    .busy_o(busy[2]), .resp_valid_o(rvld[2]), .resp_rdata_o(rdata[2]), .resp_err_o(rerr[2])
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic ref_err(logic [1:0] s, logic [31:0] a);
    return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0) ||
           (a >= 32'h4000);
  endfunction

  task automatic ref_store(int i, logic [1:0] s, logic [31:0] a, logic [31:0] d);
    for (int j = 0; j < (1 << s); j++) ref_mem[i][a + j] = d[8*j +: 8];
  endtask

  function automatic logic [31:0] ref_load(int i, logic [1:0] s, logic sg, logic [31:0] a);
    logic [31:0] v = 32'd0;
    int n = 1 << s;
    for (int j = 0; j < n; j++) v = v | (32'(ref_mem[i][a + j]) << (8 * j));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_clear(int i);
    for (int j = 0; j < 16384; j++) ref_mem[i][j] = 8'h00;
  endtask

  // Issue one request from an idle DUT; k = edges after accept until resp_valid is seen.
  task automatic do_op(int i, logic w, logic [1:0] s, logic sg, logic [31:0] a, logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int k);
    @(negedge clk);
    we = w; size = s; sgn = sg; addr = a; wdata = d; pc = $urandom; rv[i] = 1'b1;
    @(posedge clk);
    #1 rv[i] = 1'b0;
    rd = 'x; er = 'x; k = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (rvld[i]) begin
        rd = rdata[i]; er = rerr[i]; k = t;
        return;
      end
    end
  endtask

  task automatic txn(int i, logic w, logic [1:0] s, logic sg, logic [31:0] a, logic [31:0] d,
                     string name);
    logic [31:0] rd, exp_rd;
    logic er, exp_er;
    int k;
    exp_er = ref_err(s, a);
    exp_rd = (exp_er || w) ? 32'd0 : ref_load(i, s, sg, a);
    do_op(i, w, s, sg, a, d, rd, er, k);
    check({name, " rdata"}, rd, exp_rd);
    check({name, " err"}, 32'(er), 32'(exp_er));
    check({name, " latency"}, 32'(k), exp_er ? 32'd0 : 32'(lat[i]));
    if (!exp_er && w) ref_store(i, s, a, d);
  endtask

  vec_t tbl [16];

  initial begin
    logic [31:0] rd;
    logic er;
    int k, cnt;
    logic [11:0] pat12;
    logic [5:0]  pat6;
    logic [31:0] got;

    rst = 3'b111; rv = 3'b000; we = 0; size = 0; sgn = 0; addr = 0; wdata = 0; pc = 0;
    for (int i = 0; i < 3; i++) ref_clear(i);
    repeat (3) @(posedge clk);
    #1 rst = 3'b000;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset busy %0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("reset resp_valid %0d", i), 32'(rvld[i]), 32'd0);
      check($sformatf("reset rdata %0d", i), rdata[i], 32'd0);
      check($sformatf("reset err %0d", i), 32'(rerr[i]), 32'd0);
    end

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'h12345678, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 32'h11,   32'h000000AB, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h11,   32'h0,        32'hFFFFFFAB, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h11,   32'h0,        32'h000000AB, 1'b0};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h1234AB78, 1'b0};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 32'h12,   32'h00008001, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        32'hFFFF8001, 1'b0};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        32'h00008001, 1'b0};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h8001AB78, 1'b0};
    tbl[9]  = '{1'b0, 2'd1, 1'b1, 32'h13,   32'h0,        32'h0,        1'b1};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h0E,   32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1};
    tbl[12] = '{1'b1, 2'd2, 1'b0, 32'h4000, 32'hCAFEF00D, 32'h0,        1'b1};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h4000, 32'h0,        32'h0,        1'b1};
    tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h8001AB78, 1'b0};
    tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h0C,   32'h0,        32'h0,        1'b0};

    for (int v = 0; v < 16; v++) begin
      do_op(0, tbl[v].we, tbl[v].size, tbl[v].sgn, tbl[v].addr, tbl[v].wdata, rd, er, k);
      check($sformatf("vec%0d rdata", v), rd, tbl[v].exp_rd);
      check($sformatf("vec%0d err", v), 32'(er), 32'(tbl[v].exp_err));
      check($sformatf("vec%0d latency", v), 32'(k), tbl[v].exp_err ? 32'd0 : 32'd1);
      if (!tbl[v].exp_err && tbl[v].we) ref_store(0, tbl[v].size, tbl[v].addr, tbl[v].wdata);
    end

    // Response fields hold after the pulse.
    do_op(0, 1'b0, 2'd1, 1'b1, 32'h13, 32'h0, rd, er, k);
    @(negedge clk);
    check("hold err resp_valid", 32'(rvld[0]), 32'd0);
    check("hold err", 32'(rerr[0]), 32'd1);
    check("hold err rdata", rdata[0], 32'd0);
    do_op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, k);
    repeat (2) @(negedge clk);
    check("hold rdata", rdata[0], 32'h8001AB78);
    check("hold ok err", 32'(rerr[0]), 32'd0);

    // LATENCY=3: reset during WAIT aborts the store and suppresses the response.
    @(negedge clk);
    we = 1'b1; size = 2'd2; sgn = 1'b0; addr = 32'h20; wdata = 32'hDEADBEEF; rv[1] = 1'b1;
    @(posedge clk);
    #1 rv[1] = 1'b0;
    @(negedge clk);
    check("abort busy in wait", 32'(busy[1]), 32'd1);
    rst[1] = 1'b1;
    @(posedge clk);
    #1 rst[1] = 1'b0;
    ref_clear(1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rvld[1]) cnt++;
    end
    check("abort no resp", 32'(cnt), 32'd0);
    check("abort busy", 32'(busy[1]), 32'd0);
    txn(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "abort lw");

    // req_valid held through busy: next accept only once back in IDLE.
    txn(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h5A5A0001, "held sw");
    @(negedge clk);
    we = 1'b0; size = 2'd2; addr = 32'h20; rv[1] = 1'b1;
    @(posedge clk);
    pat12 = '0;
    got = 32'd0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      pat12[t] = rvld[1];
      if (t == 8) got = rdata[1];
      if (t == 5) rv[1] = 1'b0;
    end
    check("held resp pattern", 32'(pat12), 32'h108);
    check("held second rdata", got, 32'h5A5A0001);

    // LATENCY=0: back-to-back store then load to the same word.
    @(negedge clk);
    we = 1'b1; size = 2'd2; sgn = 1'b0; addr = 32'h0; wdata = 32'h0BADF00D; rv[2] = 1'b1;
    @(posedge clk);
    pat6 = '0;
    got = 32'd0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      pat6[t] = rvld[2];
      if (t == 0) we = 1'b0;
      if (t == 2) begin
        got = rdata[2];
        rv[2] = 1'b0;
      end
    end
    ref_store(2, 2'd2, 32'h0, 32'h0BADF00D);
    check("b2b resp pattern", 32'(pat6), 32'h5);
    check("b2b lw rdata", got, 32'h0BADF00D);

    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 120; n++) begin
        logic [31:0] a;
        a = $urandom_range(0, 95);
        if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(14, 31));
        txn(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, $sformatf("rand%0d.%0d", i, n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
